// File: rtl/gs_pkg.sv
// Shared definitions for the grayscale pipeline: controller state codes,
// default frame geometry and helpers for sizing frame counters and addresses.
package gs_pkg;

   // Controller states. Kept as plain constants so older tools and netlists
   // that compare raw state codes keep working.
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ARM    = 3'd1;
   localparam logic [2:0] RUN    = 3'd2;
   localparam logic [2:0] FLUSH  = 3'd3;
   localparam logic [2:0] FINISH = 3'd4;
   localparam logic [2:0] FAULT  = 3'd5;

   // Default frame geometry (rows x columns).
   localparam int unsigned GS_DEFAULT_N = 480;
   localparam int unsigned GS_DEFAULT_M = 320;

   // Pixels in one n x m frame.
   function automatic int unsigned gs_pixels(input int unsigned n, input int unsigned m);
      return n * m;
   endfunction

   // Bits needed for a counter that must be able to hold max_value itself,
   // since the frame counters saturate at the frame size rather than wrapping.
   function automatic int unsigned gs_width_for(input longint unsigned max_value);
      int unsigned w;
      w = 1;
      while ((w < 63) && ((64'd1 << w) <= max_value)) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/gs_watchdog.sv
// Stall watchdog: counts consecutive tick cycles without a clear and flags
// the tick that carries the count to TIMEOUT-1, so the owner can react on
// that same edge.
module gs_watchdog #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_tick,
   output logic o_expired
);

   localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   // Expiry fires on the tick that would move the count from TIMEOUT-2 to TIMEOUT-1.
   assign o_expired = i_tick && !i_clear && (r_count >= LAST);

   // Idle-cycle counter: activity clears it, ticks advance it, it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_tick && (r_count != SAT)) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/gs_frame_controller.sv
// Frame sequencer for one grayscale conversion: walks the RGB source
// (3 bytes per pixel), strobes gray writes as the grayscaler produces them,
// and reports done/error with a stall watchdog.
module gs_frame_controller
   import gs_pkg::*;
#(
   parameter int unsigned N       = GS_DEFAULT_N,
   parameter int unsigned M       = GS_DEFAULT_M,
   parameter int unsigned SRC_AW  = 19,
   parameter int unsigned DST_AW  = 18,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_rd_valid,
   input  logic              i_gs_pause,
   input  logic              i_gs_valid,
   input  logic              i_gs_done,
   output logic              o_rd_en,
   output logic [SRC_AW-1:0] o_rd_addr,
   output logic              o_wr_en,
   output logic [DST_AW-1:0] o_wr_addr,
   output logic              o_gs_enable,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error,
   output logic [DST_AW-1:0] o_pix_count
);

   localparam int unsigned     PIXELS   = gs_pixels(N, M);
   localparam int unsigned     DW1      = DST_AW + 1;
   localparam logic [SRC_AW-1:0] SRC_END = SRC_AW'(3 * PIXELS);
   localparam logic [DST_AW-1:0] DST_END = DST_AW'(PIXELS);
   localparam logic [DW1-1:0]    DST_END_X = DW1'(PIXELS);

   logic [2:0]        r_state;
   logic [SRC_AW-1:0] r_rd_addr;
   logic [DST_AW-1:0] r_wr_addr;
   logic              r_error;
   logic              r_rd_req;

   logic [2:0]        w_state_next;
   logic              w_error_set;
   logic              w_active;
   logic              w_rd_en;
   logic              w_wr_en;
   logic              w_overrun;
   logic              w_count_ok;
   logic              w_rd_pending;
   logic              w_expired;
   logic [DW1-1:0]    w_wr_count;

   assign w_active   = (r_state == RUN) || (r_state == FLUSH);
   assign w_rd_en    = (r_state == RUN) && !i_gs_pause && (r_rd_addr < SRC_END);
   // A result arriving with the frame already full is an overrun; it is not
   // written so the destination buffer beyond the frame stays untouched.
   assign w_overrun  = w_active && i_gs_valid && (r_wr_addr == DST_END);
   assign w_wr_en    = w_active && i_gs_valid && !w_overrun;
   // Completion check counts a write landing in the same cycle as gs_done.
   assign w_wr_count = {1'b0, r_wr_addr} + {{DST_AW{1'b0}}, w_wr_en};
   assign w_count_ok = (w_wr_count == DST_END_X);
   // The source answers one cycle after a request, so a read is outstanding
   // if one was issued last cycle or a byte is still landing now.
   assign w_rd_pending = r_rd_req || i_rd_valid;

   gs_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (!w_active || i_rd_valid || i_gs_valid || i_abort),
      .i_tick    (w_active),
      .o_expired (w_expired)
   );

   // Next-state selection; abort overrides everything outside IDLE.
   always_comb begin
      w_state_next = r_state;
      w_error_set  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_next = ARM;
            end
         end
         ARM: begin
            w_state_next = RUN;
         end
         RUN, FLUSH: begin
            if (w_overrun || w_expired || (i_gs_done && !w_count_ok)) begin
               w_state_next = FAULT;
               w_error_set  = 1'b1;
            end else if (i_gs_done) begin
               w_state_next = FINISH;
            end else if ((r_state == RUN) && (r_rd_addr == SRC_END) && !w_rd_pending) begin
               w_state_next = FLUSH;
            end
         end
         FINISH, FAULT: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      if ((r_state != IDLE) && i_abort) begin
         w_state_next = IDLE;
         w_error_set  = 1'b0;
      end
   end

   // State, frame counters and sticky error; counters freeze on abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_error   <= 1'b0;
         r_rd_req  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_rd_req <= w_rd_en;
         if ((r_state == IDLE) && i_start) begin
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_error   <= 1'b0;
         end else if (w_active && !i_abort) begin
            if (i_rd_valid && (r_rd_addr != SRC_END)) begin
               r_rd_addr <= r_rd_addr + SRC_AW'(1);
            end
            if (w_wr_en) begin
               r_wr_addr <= r_wr_addr + DST_AW'(1);
            end
         end
         if (w_error_set) begin
            r_error <= 1'b1;
         end
      end
   end

   assign o_rd_en     = w_rd_en;
   assign o_rd_addr   = r_rd_addr;
   assign o_wr_en     = w_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_pix_count = r_wr_addr;
   assign o_gs_enable = (r_state == ARM) || w_active;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = (r_state == FINISH);
   assign o_error     = r_error;

endmodule

// File: tb/tb_gs_frame_controller.sv
// Directed bench for gs_frame_controller on a 2x2 frame (4 pixels, 12 source
// bytes) with a 1-cycle-latency source model and a grayscaler model that
// emits one result per 3 bytes. Cycle numbers are counted from the ARM cycle (1).
module tb_gs_frame_controller;

   logic       clk;
   logic       rst_n;
   logic       i_start, i_abort, i_rd_valid, i_gs_pause, i_gs_valid, i_gs_done;
   logic       o_rd_en, o_wr_en, o_gs_enable, o_busy, o_done, o_error;
   logic [3:0] o_rd_addr;
   logic [2:0] o_wr_addr, o_pix_count;
   logic [15:0] outs;

   gs_frame_controller #(
      .N(2), .M(2), .SRC_AW(4), .DST_AW(3), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_rd_valid(i_rd_valid), .i_gs_pause(i_gs_pause), .i_gs_valid(i_gs_valid),
      .i_gs_done(i_gs_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_gs_enable(o_gs_enable),
      .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_pix_count(o_pix_count)
   );

   assign outs = {o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_gs_enable,
                  o_busy, o_done, o_error, o_pix_count};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   // model configuration (written by the stimulus only)
   int   src_limit, gs_n_valid, gs_done_delay;
   logic pause_en, model_clear;
   // model state (written by the model only)
   int   src_bytes, gs_bytes, gs_pix, done_cd, pause_left;
   logic cap_rd_en, cap_rd_valid;

   // per-frame observations
   int c, arm_ok, err_arm, first_rd_c, first_rd_addr, prev_addr, rd_jumps;
   int wr_pulses, wr_bad, pix_bad, done_pulses, done_c, err_c, gs_en_err;
   int idle_c, gs_en_idle, abort_c, pause_leak, np, post, post_rd_en;
   int pa [5];

   // Mid-cycle capture of what the DUT asked for and received.
   always @(negedge clk) begin
      cap_rd_en    = o_rd_en;
      cap_rd_valid = i_rd_valid;
   end

   // Source and grayscaler models, driven just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (model_clear) begin
         src_bytes = 0; gs_bytes = 0; gs_pix = 0; done_cd = 0; pause_left = 0;
         i_rd_valid = 0; i_gs_valid = 0; i_gs_done = 0; i_gs_pause = 0;
      end else begin
         i_gs_done = 0;
         if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) i_gs_done = 1;
         end
         i_gs_valid = 0;
         if (cap_rd_valid && gs_bytes < 12) begin
            gs_bytes++;
            if (gs_bytes % 3 == 0 && gs_pix < gs_n_valid) begin
               i_gs_valid = 1;
               gs_pix++;
               if (gs_pix == gs_n_valid) done_cd = gs_done_delay;
            end
            if (pause_en && gs_bytes == 4) pause_left = 5;
         end
         i_gs_pause = (pause_left > 0);
         if (pause_left > 0) pause_left--;
         i_rd_valid = cap_rd_en && (src_bytes < src_limit);
         if (i_rd_valid) src_bytes++;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      $display("check %-14s observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic prep(input int lim, input int nval, input int dly, input logic pen);
      src_limit = lim; gs_n_valid = nval; gs_done_delay = dly; pause_en = pen;
      model_clear = 1;
      @(negedge clk);
      model_clear = 0;
   endtask

   // Issues start from IDLE and samples every cycle until busy drops,
   // cycle stop_c is reached, or the budget runs out.
   task automatic run_frame(input int stop_c, input int abort_addr);
      arm_ok = 0; err_arm = -1; first_rd_c = -1; first_rd_addr = -1; prev_addr = 0;
      rd_jumps = 0; wr_pulses = 0; wr_bad = 0; pix_bad = 0; done_pulses = 0;
      done_c = -1; err_c = -1; gs_en_err = -1; idle_c = -1; gs_en_idle = -1;
      abort_c = -1; pause_leak = 0; np = 0; post = -1; post_rd_en = -1;
      i_start = 1;
      for (c = 1; c <= 200; c++) begin
         @(negedge clk);
         i_start = 0;
         i_abort = 0;
         if (c == 1) begin
            arm_ok  = int'(o_gs_enable && !o_rd_en);
            err_arm = int'(o_error);
         end
         if (o_rd_en && first_rd_c < 0) begin
            first_rd_c = c; first_rd_addr = int'(o_rd_addr);
         end
         if (c > 1 && int'(o_rd_addr) != prev_addr && int'(o_rd_addr) != prev_addr + 1) rd_jumps++;
         prev_addr = int'(o_rd_addr);
         if (o_wr_en) begin
            if (int'(o_wr_addr) != wr_pulses) wr_bad++;
            wr_pulses++;
         end
         if (o_pix_count != o_wr_addr) pix_bad++;
         if (o_done) begin done_pulses++; done_c = c; end
         if (o_error && err_c < 0) begin err_c = c; gs_en_err = int'(o_gs_enable); end
         if (i_gs_pause) begin
            if (o_rd_en) pause_leak++;
            if (np < 5) pa[np] = int'(o_rd_addr);
            np++;
         end else if (np == 5 && post < 0) begin
            post = int'(o_rd_addr); post_rd_en = int'(o_rd_en);
         end
         if (!o_busy) begin idle_c = c; gs_en_idle = int'(o_gs_enable); break; end
         if (c == stop_c) break;
         if (abort_addr >= 0 && abort_c < 0 && int'(o_rd_addr) == abort_addr) begin
            i_abort = 1; abort_c = c;
         end
      end
      if (stop_c == 0) chk("frame_ends", int'(idle_c > 0), 1);
   endtask

   initial begin
      rst_n = 0; i_start = 0; i_abort = 0; model_clear = 1; pause_en = 0;
      src_limit = 12; gs_n_valid = 4; gs_done_delay = 2;
      repeat (2) @(negedge clk);
      chk("reset_outs", int'(outs), 0);
      rst_n = 1;
      @(negedge clk);

      // nominal frame
      prep(12, 4, 2, 0);
      run_frame(0, -1);
      chk("nom_arm", arm_ok, 1);
      chk("nom_first_rd_c", first_rd_c, 2);
      chk("nom_first_addr", first_rd_addr, 0);
      chk("nom_rd_jumps", rd_jumps, 0);
      chk("nom_wr_pulses", wr_pulses, 4);
      chk("nom_wr_addrs", wr_bad, 0);
      chk("nom_pix_count", pix_bad, 0);
      chk("nom_done_n", done_pulses, 1);
      chk("nom_done_c", done_c, 18);
      chk("nom_idle_c", idle_c, 19);
      chk("nom_error", err_c, -1);
      chk("nom_rd_final", int'(o_rd_addr), 12);
      chk("nom_wr_final", int'(o_wr_addr), 4);

      // pause for 5 cycles after byte 3
      prep(12, 4, 2, 1);
      run_frame(0, -1);
      chk("pause_cycles", np, 5);
      chk("pause_rd_en", pause_leak, 0);
      chk("pause_addr0", pa[0], 4);
      chk("pause_addr1", pa[1], 5);
      chk("pause_addr4", pa[4], 5);
      chk("pause_post", post, 5);
      chk("pause_post_en", post_rd_en, 1);
      chk("pause_done_c", done_c, 23);
      chk("pause_wr", wr_pulses, 4);
      chk("pause_error", err_c, -1);

      // stall after byte 5
      prep(6, 4, 2, 0);
      run_frame(0, -1);
      chk("stall_err_c", err_c, 25);
      chk("stall_gs_en", gs_en_err, 0);
      chk("stall_idle_c", idle_c, 26);
      chk("stall_done", done_pulses, 0);
      chk("stall_wr", wr_pulses, 2);
      repeat (3) @(negedge clk);
      chk("stall_sticky", int'(o_error), 1);

      // gs_done after only 3 results
      prep(12, 3, 2, 0);
      run_frame(0, -1);
      chk("mis_err_clr", err_arm, 0);
      chk("mis_err_c", err_c, 15);
      chk("mis_idle_c", idle_c, 16);
      chk("mis_done", done_pulses, 0);
      chk("mis_wr", wr_pulses, 3);

      // abort at rd_addr 7, then a clean frame
      prep(12, 4, 2, 0);
      run_frame(0, 7);
      chk("abort_c", abort_c, 10);
      chk("abort_idle_c", idle_c, 11);
      chk("abort_gs_en", gs_en_idle, 0);
      chk("abort_error", int'(o_error), 0);
      chk("abort_done", done_pulses, 0);
      repeat (2) @(negedge clk);
      prep(12, 4, 2, 0);
      run_frame(0, -1);
      chk("reab_first", first_rd_addr, 0);
      chk("reab_done_c", done_c, 18);
      chk("reab_wr", wr_pulses, 4);
      chk("reab_error", err_c, -1);

      // asynchronous reset in FLUSH
      prep(12, 4, 6, 0);
      run_frame(19, -1);
      chk("rst_pre_busy", int'(o_busy), 1);
      chk("rst_pre_rd_en", int'(o_rd_en), 0);
      chk("rst_pre_addr", int'(o_rd_addr), 12);
      #2 rst_n = 0;
      #1;
      chk("rst_async", int'(outs), 0);
      @(negedge clk);
      rst_n = 1;
      prep(12, 4, 2, 0);
      run_frame(0, -1);
      chk("rst_after_arm", arm_ok, 1);
      chk("rst_after_done", done_c, 18);
      chk("rst_after_wr", wr_pulses, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
